// File: rtl/demultiplexor1_collector.sv
// -----------------------------------------------------------------------------
// demultiplexor1_collector
//
// Receive-side partner of the 8:1 bit multiplexor. A stream of (select, bit)
// pairs arrives over a single-bit link. Each bit is steered into the lane named
// by its select. When every lane has been written at least once, the assembled
// word is offered downstream through a valid/ready handshake.
//
// Parameters:
//   SEL_W     - select width; the word has WIDTH = 2**SEL_W lanes
//
// Ports:
//   clk       - rising-edge clock, the only clock domain
//   rst       - synchronous, active-high reset
//   in_valid  - in_sel/in_bit carry a pair this cycle
//   in_sel    - lane index the bit is written to
//   in_bit    - bit value stored at lane in_sel
//   in_ready  - the collector takes a pair this cycle (COLLECT state)
//   out_valid - the assembled word is on out_data (FULL state)
//   out_data  - assembled word; bit k is the last bit written to lane k
//   out_ready - downstream takes the word this cycle
//   flush     - (DEMUX_COLLECTOR_FLUSH_EN only) emit a partial word now
//   out_mask  - (DEMUX_COLLECTOR_FLUSH_EN only) lanes written in out_data
//
// Optional feature macro: DEMUX_COLLECTOR_FLUSH_EN
//   Undefined (default): a word is emitted only once all lanes are written.
//   Defined: adds the flush input and the out_mask output.
// -----------------------------------------------------------------------------
module demultiplexor1_collector #(
    parameter  int SEL_W = 3,
    localparam int WIDTH = 1 << SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
`ifdef DEMUX_COLLECTOR_FLUSH_EN
    input  logic             flush,
    output logic [WIDTH-1:0] out_mask,
`endif
    input  logic             out_ready
);

    typedef enum logic {
        COLLECT,
        FULL
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] mask_next;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] data_next;

    // State, lane mask and data word are all registered here. Reset throws
    // away any partial or held word, so nothing half-built ever reaches the
    // output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
            mask  <= '0;
            data  <= '0;
        end else begin
            state <= state_next;
            mask  <= mask_next;
            data  <= data_next;
        end
    end

    // Next-state logic. While collecting, an accepted pair writes its lane
    // (last write wins) and marks it in the mask. The move to FULL looks at the
    // mask that already includes this cycle's lane, so the final missing lane
    // and the transition happen on the same edge. In FULL the word is frozen
    // until downstream takes it; then both registers are cleared so no bit can
    // leak into the next word.
    always_comb begin
        state_next = state;
        mask_next  = mask;
        data_next  = data;

        case (state)
            COLLECT: begin
                if (in_valid) begin
                    data_next[in_sel] = in_bit;
                    mask_next[in_sel] = 1'b1;
                end
                if (&mask_next) begin
                    state_next = FULL;
                end
`ifdef DEMUX_COLLECTOR_FLUSH_EN
                // A flush on an empty mask would emit an all-invalid word,
                // so it is only honoured once at least one lane holds data.
                else if (flush && (mask_next != '0)) begin
                    state_next = FULL;
                end
`endif
            end

            FULL: begin
                if (out_ready) begin
                    state_next = COLLECT;
                    mask_next  = '0;
                    data_next  = '0;
                end
            end

            default: begin
                state_next = COLLECT;
                mask_next  = '0;
                data_next  = '0;
            end
        endcase
    end

    // Handshake outputs come straight from the state register, which keeps
    // every input-to-output path registered.
    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == FULL);
    assign out_data  = data;

`ifdef DEMUX_COLLECTOR_FLUSH_EN
    assign out_mask  = mask;
`endif

endmodule

// File: tb/tb_demultiplexor1_collector.sv
// -----------------------------------------------------------------------------
// tb_demultiplexor1_collector
//
// Self-checking bench for demultiplexor1_collector (default SEL_W = 3).
// A behavioural model keeps one value per lane plus a "seen" flag per lane and
// declares the word complete once the number of distinct lanes seen reaches
// WIDTH. Directed sequences cover the walkthrough cases; a randomized run
// (with occasional resets and, when built with DEMUX_COLLECTOR_FLUSH_EN,
// occasional flushes) follows.
// -----------------------------------------------------------------------------
module tb_demultiplexor1_collector;

    localparam int SEL_W = 3;
    localparam int WIDTH = 1 << SEL_W;

    logic             clk      = 1'b0;
    logic             rst      = 1'b0;
    logic             inValid  = 1'b0;
    logic [SEL_W-1:0] inSel    = '0;
    logic             inBit    = 1'b0;
    logic             outReady = 1'b0;
    logic             inReady;
    logic             outValid;
    logic [WIDTH-1:0] outData;
`ifdef DEMUX_COLLECTOR_FLUSH_EN
    logic             flush    = 1'b0;
    logic [WIDTH-1:0] outMask;
`endif

    int testsRun  = 0;
    int failCount = 0;

    bit modelLane [WIDTH];
    bit modelSeen [WIDTH];
    bit modelFull;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    demultiplexor1_collector #(.SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_sel    (inSel),
        .in_bit    (inBit),
        .in_ready  (inReady),
        .out_valid (outValid),
        .out_data  (outData),
`ifdef DEMUX_COLLECTOR_FLUSH_EN
        .flush     (flush),
        .out_mask  (outMask),
`endif
        .out_ready (outReady)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int countSeen();
        int n = 0;
        for (int i = 0; i < WIDTH; i++) n += int'(modelSeen[i]);
        return n;
    endfunction

    function automatic logic [WIDTH-1:0] packData();
        logic [WIDTH-1:0] w = '0;
        for (int i = 0; i < WIDTH; i++) w[i] = modelLane[i];
        return w;
    endfunction

    function automatic logic [WIDTH-1:0] packSeen();
        logic [WIDTH-1:0] w = '0;
        for (int i = 0; i < WIDTH; i++) w[i] = modelSeen[i];
        return w;
    endfunction

    task automatic modelClear();
        for (int i = 0; i < WIDTH; i++) begin
            modelLane[i] = 1'b0;
            modelSeen[i] = 1'b0;
        end
        modelFull = 1'b0;
    endtask

    // What one clock edge does to the word being collected.
    task automatic modelEdge();
        if (rst) begin
            modelClear();
        end else if (!modelFull) begin
            if (inValid) begin
                modelLane[int'(inSel)] = inBit;
                modelSeen[int'(inSel)] = 1'b1;
            end
            if (countSeen() == WIDTH) modelFull = 1'b1;
`ifdef DEMUX_COLLECTOR_FLUSH_EN
            else if (flush && countSeen() > 0) modelFull = 1'b1;
`endif
        end else if (outReady) begin
            modelClear();
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then check the
    // registered outputs 1 ns after the edge.
    task automatic applyStimulus(input logic v, input logic [SEL_W-1:0] sel,
                                 input logic b, input logic ordy);
        inValid  = v;
        inSel    = sel;
        inBit    = b;
        outReady = ordy;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("in_ready", 32'(inReady), 32'(!modelFull));
        checkOutput("out_valid", 32'(outValid), 32'(modelFull));
        if (modelFull) checkOutput("out_data", 32'(outData), 32'(packData()));
`ifdef DEMUX_COLLECTOR_FLUSH_EN
        if (modelFull) checkOutput("out_mask", 32'(outMask), 32'(packSeen()));
`endif
    endtask

    task automatic fillWord(input logic [WIDTH-1:0] word, input logic ordy);
        for (int k = 0; k < WIDTH; k++) applyStimulus(1'b1, SEL_W'(k), word[k], ordy);
    endtask

    initial begin
        int oooSel [9] = '{7, 3, 3, 0, 1, 2, 4, 5, 6};
        bit oooBit [9] = '{1, 1, 0, 1, 1, 1, 1, 1, 1};
        logic [WIDTH-1:0] word;

        modelClear();

        // Reset state.
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd2, 1'b1, 1'b1);
        rst = 1'b0;
        checkOutput("reset_in_ready", 32'(inReady), 32'd1);
        checkOutput("reset_out_valid", 32'(outValid), 32'd0);
        checkOutput("reset_out_data", 32'(outData), 32'd0);
`ifdef DEMUX_COLLECTOR_FLUSH_EN
        checkOutput("reset_out_mask", 32'(outMask), 32'd0);
`endif

        // In-order fill: lanes 0..7 get 1,0,1,1,0,0,1,0.
        fillWord(8'b01001101, 1'b1);
        checkOutput("fill_valid", 32'(outValid), 32'd1);
        checkOutput("fill_data", 32'(outData), 32'h4D);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("fill_ready_again", 32'(inReady), 32'd1);

        // Out-of-order arrival with lane 3 rewritten.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, SEL_W'(oooSel[i]), oooBit[i], 1'b1);
            if (i < 8) checkOutput("ooo_early_valid", 32'(outValid), 32'd0);
        end
        checkOutput("ooo_valid", 32'(outValid), 32'd1);
        checkOutput("ooo_data", 32'(outData), 32'hF7);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Backpressure: word is held while in_valid keeps toggling lanes.
        fillWord(8'hA5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, SEL_W'($urandom_range(0, WIDTH-1)), 1'($urandom_range(0, 1)), 1'b0);
            checkOutput("bp_data", 32'(outData), 32'hA5);
            checkOutput("bp_in_ready", 32'(inReady), 32'd0);
        end
        applyStimulus(1'b1, 3'd1, 1'b0, 1'b1);
        checkOutput("bp_collect", 32'(inReady), 32'd1);
        applyStimulus(1'b1, 3'd0, 1'b1, 1'b1);
        checkOutput("bp_mask_clear", 32'(outValid), 32'd0);

        // Reset mid-collection discards the partial word.
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, SEL_W'(k), 1'b1, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        rst = 1'b0;
        checkOutput("rst_mid_valid", 32'(outValid), 32'd0);
        checkOutput("rst_mid_data", 32'(outData), 32'd0);
        word = 8'hAA;
        for (int k = 5; k < 8; k++) begin
            applyStimulus(1'b1, SEL_W'(k), word[k], 1'b1);
            checkOutput("rst_partial_valid", 32'(outValid), 32'd0);
        end
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, SEL_W'(k), word[k], 1'b1);
        checkOutput("rst_refill_valid", 32'(outValid), 32'd1);
        checkOutput("rst_refill_data", 32'(outData), 32'hAA);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Back-to-back words separated only by the handshake cycle.
        fillWord(8'h3C, 1'b1);
        checkOutput("b2b_first", 32'(outData), 32'h3C);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        fillWord(8'hC3, 1'b1);
        checkOutput("b2b_second_valid", 32'(outValid), 32'd1);
        checkOutput("b2b_second", 32'(outData), 32'hC3);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);

`ifdef DEMUX_COLLECTOR_FLUSH_EN
        // Partial word via flush, then a flush with nothing collected.
        applyStimulus(1'b1, 3'd0, 1'b1, 1'b1);
        applyStimulus(1'b1, 3'd2, 1'b1, 1'b1);
        flush = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        flush = 1'b0;
        checkOutput("flush_valid", 32'(outValid), 32'd1);
        checkOutput("flush_data", 32'(outData), 32'h05);
        checkOutput("flush_mask", 32'(outMask), 32'h05);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        flush = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        flush = 1'b0;
        checkOutput("flush_empty_valid", 32'(outValid), 32'd0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
`ifdef DEMUX_COLLECTOR_FLUSH_EN
            flush = ($urandom_range(0, 19) == 0);
`endif
            applyStimulus($urandom_range(0, 9) < 7, SEL_W'($urandom_range(0, WIDTH-1)),
                          1'($urandom_range(0, 1)), $urandom_range(0, 1) == 1);
        end
        rst = 1'b0;
`ifdef DEMUX_COLLECTOR_FLUSH_EN
        flush = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
